// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared channel state encoding and default timing constants for the button front end
package btn_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int DEF_NUM_BTN           = 4;
    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYC      = 1_000_000;
    localparam int DEF_REPEAT_DELAY_CYC  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD_CYC = 10_000_000;

    // Width that holds 0..max_val inclusive, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, debounce FSM, auto-repeat when BTN_AUTOREPEAT_EN is defined
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic                   rep_fire;

    // Pure shift chain: nothing combinational ahead of the final flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef BTN_AUTOREPEAT_EN
    // rcnt runs 0..DELAY-1 once, then reloads so each later lap is PERIOD long (PERIOD <= DELAY).
    localparam int             RCW       = cnt_width(REPEAT_DELAY_CYC);
    localparam logic [RCW-1:0] RC_LAST   = RCW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RCW-1:0] RC_RELOAD = RCW'(REPEAT_DELAY_CYC - REPEAT_PERIOD_CYC);

    logic [RCW-1:0] rcnt;

    assign rep_fire = (state == ST_PRESSED) && s && (rcnt == RC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
        end else if (state != ST_PRESSED) begin
            rcnt <= '0;
        end else if (s) begin
            rcnt <= rep_fire ? RC_RELOAD : rcnt + 1'b1;
        end
    end
`else
    logic unused_repeat_cfg;

    assign unused_repeat_cfg = ^{REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC};
    assign rep_fire          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else if (rep_fire) begin
                        btn_press <= 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button front end, NUM_BTN debounced channels; BTN_AUTOREPEAT_EN adds auto-repeat
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN           = DEF_NUM_BTN,
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               btn_any
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

    // Combinational OR of registered strobes so it lines up with btn_press.
    always_comb begin
        btn_any = |btn_press;
    end

endmodule
